// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter: FSM state encodings,
// default sizing and the owner-index width rule.
// Optional feature macro used by this slice: REG_ARB_LOCK_EN.
package reg_arb_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    // Owner index width: clog2 of the requester count, never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/register side bundle of the write arbiter.
// The lock vector exists only when REG_ARB_LOCK_EN is defined.
// Handshake: a requester raises req with its word on req_data; the arbiter
// answers with gnt during the single ena cycle and a one-cycle ack pulse once
// the register holds the word. req must be dropped in the ack cycle; req and
// req_data are ignored while busy.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = idx_width(N_REQ)
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       data;
    logic                   ena;
    logic [IDX_W-1:0]       owner;
    logic                   busy;
`ifdef REG_ARB_LOCK_EN
    logic [N_REQ-1:0]       lock;

    modport master (output req, req_data, lock,
                    input  gnt, ack, data, ena, owner, busy);
    modport slave  (input  req, req_data, lock,
                    output gnt, ack, data, ena, owner, busy);
`else
    modport master (output req, req_data,
                    input  gnt, ack, data, ena, owner, busy);
    modport slave  (input  req, req_data,
                    output gnt, ack, data, ena, owner, busy);
`endif
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after ptr wins,
// wrapping from N_REQ-1 back to 0; ptr itself is considered last.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enable-loaded register between N_REQ writers.
// IDLE arbitrates and latches the winner's word, WRITE drives ena/gnt for one
// cycle, ACK pulses the owner's ack. With REG_ARB_LOCK_EN defined, a locked
// owner still requesting goes straight from ACK back to WRITE.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_write_arbiter_if.slave  bus,
    output logic [1:0]          state_dbg
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             lock_hold;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (bus.req),
        .ptr   (owner_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef REG_ARB_LOCK_EN
    assign lock_hold = (state_q == ST_ACK) && bus.lock[owner_q] && bus.req[owner_q];
`else
    assign lock_hold = 1'b0;
`endif

    // Next-state logic: arbitrate in IDLE, one WRITE cycle, one ACK cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_ACK;
            ST_ACK:   state_d = lock_hold ? ST_WRITE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, latched word and owner; owner moves only on a grant so idle keeps fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            owner_q <= IDX_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && pick_valid) begin
                data_q  <= bus.req_data[pick_idx*WIDTH +: WIDTH];
                owner_q <= pick_idx;
            end else if (lock_hold) begin
                data_q  <= bus.req_data[owner_q*WIDTH +: WIDTH];
            end
        end
    end

    // Output decode from the registered state so reset clears ena/gnt/ack at once.
    always_comb begin
        bus.gnt   = (state_q == ST_WRITE) ? (N_REQ'(1) << owner_q) : '0;
        bus.ack   = (state_q == ST_ACK)   ? (N_REQ'(1) << owner_q) : '0;
        bus.ena   = (state_q == ST_WRITE);
        bus.busy  = (state_q != ST_IDLE);
        bus.data  = data_q;
        bus.owner = owner_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a model register captures data on ena,
// each scenario task checks outputs on the falling clock edge.
// The lock scenario is compiled in when REG_ARB_LOCK_EN is defined.
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    logic [W-1:0] r_q;
    int n_cmp;
    int n_bad;

    reg_write_arbiter_if #(.N_REQ(N), .WIDTH(W), .IDX_W(2)) bus ();

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .IDX_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of the external register: loads data when ena is high.
    always @(posedge clk) begin
        if (bus.ena) r_q <= bus.data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic set_word(input int i, input logic [W-1:0] v);
        bus.req_data[i*W +: W] = v;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_write(input logic [N-1:0] r, input int i, input logic [W-1:0] v);
        bus.req = r;
        set_word(i, v);
        @(negedge clk);
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.req = '0;
        bus.req_data = '0;
`ifdef REG_ARB_LOCK_EN
        bus.lock = '0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #7;
        n_cmp++; if (bus.ena !== 1'b0) begin n_bad++; $display("FAIL rst_ena: got %b want 0", bus.ena); end
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt); end
        n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL rst_ack: got %b want 0000", bus.ack); end
        n_cmp++; if (bus.data !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", bus.data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.owner !== 2'd3) begin n_bad++; $display("FAIL rst_owner: got %0d want 3", bus.owner); end
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        bus.req = 4'b0001;
        set_word(0, 8'hA5);
        @(negedge clk);
        n_cmp++; if (bus.ena !== 1'b1) begin n_bad++; $display("FAIL t1_ena: got %b want 1", bus.ena); end
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL t1_gnt: got %b want 0001", bus.gnt); end
        n_cmp++; if (bus.data !== 8'hA5) begin n_bad++; $display("FAIL t1_data: got %h want a5", bus.data); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy_w: got %b want 1", bus.busy); end
        n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL t1_ack_w: got %b want 0000", bus.ack); end
        @(negedge clk);
        n_cmp++; if (bus.ack !== 4'b0001) begin n_bad++; $display("FAIL t1_ack: got %b want 0001", bus.ack); end
        n_cmp++; if (r_q !== 8'hA5) begin n_bad++; $display("FAIL t1_r: got %h want a5", r_q); end
        n_cmp++; if (bus.ena !== 1'b0) begin n_bad++; $display("FAIL t1_ena_ack: got %b want 0", bus.ena); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy_a: got %b want 1", bus.busy); end
        bus.req = '0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t1_busy_i: got %b want 0", bus.busy); end
        n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL t1_ack_i: got %b want 0000", bus.ack); end
        n_cmp++; if (bus.owner !== 2'd0) begin n_bad++; $display("FAIL t1_owner: got %0d want 0", bus.owner); end
    endtask

    task automatic test_round_robin;
        logic [W-1:0] words [N];
        int order [5];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        order = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) set_word(i, words[i]);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (bus.gnt !== (4'b0001 << order[k])) begin n_bad++; $display("FAIL t2_gnt%0d: got %b want %b", k, bus.gnt, 4'b0001 << order[k]); end
            n_cmp++; if (bus.data !== words[order[k]]) begin n_bad++; $display("FAIL t2_data%0d: got %h want %h", k, bus.data, words[order[k]]); end
            @(negedge clk);
            n_cmp++; if (bus.ack !== (4'b0001 << order[k])) begin n_bad++; $display("FAIL t2_ack%0d: got %b want %b", k, bus.ack, 4'b0001 << order[k]); end
            n_cmp++; if (r_q !== words[order[k]]) begin n_bad++; $display("FAIL t2_r%0d: got %h want %h", k, r_q, words[order[k]]); end
            if (k == 4) bus.req = '0;
            @(negedge clk);
            n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL t2_idle%0d: got %0d want 0", k, state_dbg); end
        end
    endtask

    task automatic test_wrap;
        run_write(4'b0100, 2, 8'h3C);
        n_cmp++; if (bus.owner !== 2'd2) begin n_bad++; $display("FAIL t3_owner2: got %0d want 2", bus.owner); end
        bus.req = 4'b0101;
        set_word(0, 8'h0A);
        set_word(2, 8'h2A);
        @(negedge clk);
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL t3_gnt: got %b want 0001", bus.gnt); end
        n_cmp++; if (bus.owner !== 2'd0) begin n_bad++; $display("FAIL t3_owner: got %0d want 0", bus.owner); end
        n_cmp++; if (bus.data !== 8'h0A) begin n_bad++; $display("FAIL t3_data: got %h want 0a", bus.data); end
        bus.req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        bus.req = '0;
        run_write(4'b0000, 0, 8'h00);
    endtask

    task automatic test_drop_after_grant;
        bus.req = 4'b0010;
        set_word(1, 8'h5C);
        @(negedge clk);
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL t4_gnt: got %b want 0010", bus.gnt); end
        bus.req = '0;
        set_word(1, 8'hFF);
        @(negedge clk);
        n_cmp++; if (bus.ack !== 4'b0010) begin n_bad++; $display("FAIL t4_ack: got %b want 0010", bus.ack); end
        n_cmp++; if (r_q !== 8'h5C) begin n_bad++; $display("FAIL t4_r: got %h want 5c", r_q); end
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.data !== 8'h5C) begin n_bad++; $display("FAIL t4_data_hold: got %h want 5c", bus.data); end
        n_cmp++; if (bus.owner !== 2'd1) begin n_bad++; $display("FAIL t4_owner: got %0d want 1", bus.owner); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t4_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_write;
        bus.req = 4'b0100;
        set_word(2, 8'h77);
        @(negedge clk);
        n_cmp++; if (bus.ena !== 1'b1) begin n_bad++; $display("FAIL t5_ena_pre: got %b want 1", bus.ena); end
        bus.req = '0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.ena !== 1'b0) begin n_bad++; $display("FAIL t5_ena: got %b want 0", bus.ena); end
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL t5_gnt: got %b want 0000", bus.gnt); end
        n_cmp++; if (bus.owner !== 2'd3) begin n_bad++; $display("FAIL t5_owner: got %0d want 3", bus.owner); end
        @(negedge clk);
        n_cmp++; if (bus.ack !== 4'b0000) begin n_bad++; $display("FAIL t5_ack: got %b want 0000", bus.ack); end
        n_cmp++; if (r_q !== 8'h5C) begin n_bad++; $display("FAIL t5_r_kept: got %h want 5c", r_q); end
        rst_n = 1'b1;
        bus.req = 4'b1000;
        set_word(3, 8'h9E);
        @(negedge clk);
        n_cmp++; if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL t5_gnt2: got %b want 1000", bus.gnt); end
        n_cmp++; if (bus.data !== 8'h9E) begin n_bad++; $display("FAIL t5_data2: got %h want 9e", bus.data); end
        @(negedge clk);
        n_cmp++; if (bus.ack !== 4'b1000) begin n_bad++; $display("FAIL t5_ack2: got %b want 1000", bus.ack); end
        n_cmp++; if (r_q !== 8'h9E) begin n_bad++; $display("FAIL t5_r2: got %h want 9e", r_q); end
        bus.req = '0;
        @(negedge clk);
    endtask

`ifdef REG_ARB_LOCK_EN
    task automatic test_lock_burst;
        logic [W-1:0] burst [3];
        burst = '{8'hB1, 8'hB2, 8'hB3};
        run_write(4'b0001, 0, 8'hA0);
        bus.req  = 4'b0011;
        bus.lock = 4'b0010;
        set_word(1, burst[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL t6_gnt%0d: got %b want 0010", k, bus.gnt); end
            n_cmp++; if (bus.data !== burst[k]) begin n_bad++; $display("FAIL t6_data%0d: got %h want %h", k, bus.data, burst[k]); end
            @(negedge clk);
            n_cmp++; if (bus.ack !== 4'b0010) begin n_bad++; $display("FAIL t6_ack%0d: got %b want 0010", k, bus.ack); end
            n_cmp++; if (r_q !== burst[k]) begin n_bad++; $display("FAIL t6_r%0d: got %h want %h", k, r_q, burst[k]); end
            if (k < 2) begin
                set_word(1, burst[k+1]);
            end else begin
                bus.lock = '0;
                bus.req  = 4'b0001;
            end
        end
        @(negedge clk);
        n_cmp++; if (state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL t6_idle: got %0d want 0", state_dbg); end
        @(negedge clk);
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL t6_gnt_next: got %b want 0001", bus.gnt); end
        n_cmp++; if (bus.data !== 8'hA0) begin n_bad++; $display("FAIL t6_data_next: got %h want a0", bus.data); end
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_wrap();
        test_drop_after_grant();
        test_reset_mid_write();
`ifdef REG_ARB_LOCK_EN
        test_lock_burst();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
